uart_arbiter: RTL

Packet-level arbiter that shares the single `uart_tx` byte channel between two byte-stream sources: port 0 carries captured LPC records from the memory read-out path, port 1 carries status/diagnostic records (e.g. overflow reports). It grants whole packets in round-robin order, paces bytes against the UART ready/strobe handshake, and aborts a packet whose owner stalls mid-packet. It sits between the read-out/status sources and `uart_tx` in the `ext_clock` domain.

---
 rtl/uart_arbiter.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_arbiter.sv
// ---------------------------------------------------------------------------
// uart_arbiter
//
// Shares the single uart_tx byte channel between two byte-stream sources.
// Port 0 carries captured LPC records from the memory read-out path. Port 1
// carries status/diagnostic records. Whole packets are granted in
// round-robin order. Each byte is paced against the uart_tx ready/strobe
// handshake. A packet whose owner stalls mid-packet is aborted after TIMEOUT
// cycles.
//
// Parameters
//   TIMEOUT            mid-packet stall limit in clock cycles (2..65535)
//
// Ports
//   clock              ext_clock domain clock
//   reset              asynchronous, active-low reset
//   srcN_valid         port N presents a byte on srcN_data
//   srcN_data[7:0]     port N byte
//   srcN_last          srcN_data is the final byte of the packet
//   srcN_ready         port N byte accepted this cycle (combinational)
//   uart_ready         uart_tx can take a byte
//   uart_data[7:0]     registered byte to uart_tx read_data
//   uart_clock_enable  one-cycle load strobe to uart_tx read_clock
//   grant[1:0]         one-hot current owner, 00 when idle
//   abort              one-cycle pulse when a packet is abandoned on timeout
//   dbg_state[2:0]     current FSM state, for observation only
//
// Optional feature
//   UART_ARBITER_SYNC_EN  When defined, every granted packet is preceded by
//                         a header byte (0xA5 for port 0, 0x5A for port 1).
//                         A timed-out packet is closed with a 0xFF trailer.
//
// Handshake
//   A source byte transfers on a rising clock edge where srcN_valid and
//   srcN_ready are both high. srcN_ready never depends on srcN_data or
//   srcN_last. A source may drop valid or last while ready is low. Data and
//   last are only sampled on the transfer edge. The uart side has no
//   back-pressure after the strobe: a byte is loaded only when uart_ready was
//   high. The following HOLD cycle gives uart_tx time to drop uart_ready
//   before the next byte is offered.
// ---------------------------------------------------------------------------
module uart_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       src0_valid,
    input  logic [7:0] src0_data,
    input  logic       src0_last,
    output logic       src0_ready,
    input  logic       src1_valid,
    input  logic [7:0] src1_data,
    input  logic       src1_last,
    output logic       src1_ready,
    input  logic       uart_ready,
    output logic [7:0] uart_data,
    output logic       uart_clock_enable,
    output logic [1:0] grant,
    output logic       abort,
    output logic [2:0] dbg_state
);

    // Stall counter terminal value. The counter value equals the number of
    // completed stall cycles, so matching TIMEOUT-1 marks the final stall
    // cycle.
    localparam logic [15:0] TO_MAX = 16'(TIMEOUT - 1);

`ifdef UART_ARBITER_SYNC_EN
    localparam logic [7:0] HDR_PORT0 = 8'hA5;
    localparam logic [7:0] HDR_PORT1 = 8'h5A;
    localparam logic [7:0] TRAILER   = 8'hFF;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_HOLD  = 3'd2
`ifdef UART_ARBITER_SYNC_EN
        ,
        ST_SYNC  = 3'd3,
        ST_TRAIL = 3'd4
`endif
    } state_t;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t      r_state;
    logic [1:0]  r_grant;
    logic        r_last_served;   // index of the port whose packet ended last
    logic [15:0] r_cnt;
    logic [7:0]  r_uart_data;
    logic        r_strobe;
    logic        r_hold_end;      // byte in HOLD closes the packet

    // -----------------------------------------------------------------------
    // Next-state / combinational signals
    // -----------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [1:0]  w_grant_nxt;
    logic        w_last_served_nxt;
    logic [15:0] w_cnt_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_strobe_nxt;
    logic        w_hold_end_nxt;
    logic        w_abort;

    logic        w_in_send;
    logic        w_sel_valid;
    logic [7:0]  w_sel_data;
    logic        w_sel_last;
    logic        w_accept;
    logic        w_pick1;

    // Mux the granted source. Outside SEND the selection is unused.
    assign w_sel_valid = r_grant[1] ? src1_valid : src0_valid;
    assign w_sel_data  = r_grant[1] ? src1_data  : src0_data;
    assign w_sel_last  = r_grant[1] ? src1_last  : src0_last;

    assign w_in_send = (r_state == ST_SEND);
    assign w_accept  = w_in_send & uart_ready & w_sel_valid;

    // Round-robin tie break: port 1 wins only when port 0 is absent or port 0
    // owned the previous packet.
    assign w_pick1 = src1_valid & (~src0_valid | ~r_last_served);

    // Ready is gated by state so that reset drives it low at once.
    assign src0_ready = w_in_send & r_grant[0] & uart_ready & src0_valid;
    assign src1_ready = w_in_send & r_grant[1] & uart_ready & src1_valid;

    assign uart_data         = r_uart_data;
    assign uart_clock_enable = r_strobe;
    assign grant             = r_grant;
    assign abort             = w_abort;
    assign dbg_state         = r_state;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= 2'b00;
            r_last_served <= 1'b1;
            r_cnt         <= 16'd0;
            r_uart_data   <= 8'h00;
            r_strobe      <= 1'b0;
            r_hold_end    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_last_served <= w_last_served_nxt;
            r_cnt         <= w_cnt_nxt;
            r_uart_data   <= w_data_nxt;
            r_strobe      <= w_strobe_nxt;
            r_hold_end    <= w_hold_end_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_last_served_nxt = r_last_served;
        w_cnt_nxt         = r_cnt;
        w_data_nxt        = r_uart_data;
        w_strobe_nxt      = 1'b0;
        w_hold_end_nxt    = r_hold_end;
        w_abort           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = 16'd0;
                if (src0_valid || src1_valid) begin
                    w_grant_nxt = w_pick1 ? 2'b10 : 2'b01;
`ifdef UART_ARBITER_SYNC_EN
                    w_state_nxt = ST_SYNC;
`else
                    w_state_nxt = ST_SEND;
`endif
                end
            end

`ifdef UART_ARBITER_SYNC_EN
            // Header byte; paced by the UART only, the stall timer is idle.
            ST_SYNC: begin
                if (uart_ready) begin
                    w_data_nxt     = r_grant[1] ? HDR_PORT1 : HDR_PORT0;
                    w_strobe_nxt   = 1'b1;
                    w_hold_end_nxt = 1'b0;
                    w_state_nxt    = ST_HOLD;
                end
            end

            // Trailer closing an aborted packet; grant stays with the
            // aborted owner until the trailer has been loaded.
            ST_TRAIL: begin
                if (uart_ready) begin
                    w_data_nxt     = TRAILER;
                    w_strobe_nxt   = 1'b1;
                    w_hold_end_nxt = 1'b1;
                    w_state_nxt    = ST_HOLD;
                end
            end
`endif

            ST_SEND: begin
                if (w_accept) begin
                    w_data_nxt     = w_sel_data;
                    w_strobe_nxt   = 1'b1;
                    w_hold_end_nxt = w_sel_last;
                    w_cnt_nxt      = 16'd0;
                    w_state_nxt    = ST_HOLD;
                end else if (!w_sel_valid) begin
                    // Only a silent owner counts as a stall. A valid byte
                    // waiting on a busy UART leaves the counter untouched.
                    if (r_cnt == TO_MAX) begin
                        w_abort   = 1'b1;
                        w_cnt_nxt = 16'd0;
`ifdef UART_ARBITER_SYNC_EN
                        w_state_nxt = ST_TRAIL;
`else
                        w_state_nxt       = ST_IDLE;
                        w_grant_nxt       = 2'b00;
                        w_last_served_nxt = r_grant[1];
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
            end

            // One cycle spent here while the strobe is high covers the
            // latency of uart_tx dropping uart_ready.
            ST_HOLD: begin
                if (r_hold_end) begin
                    w_state_nxt       = ST_IDLE;
                    w_grant_nxt       = 2'b00;
                    w_last_served_nxt = r_grant[1];
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

endmodule
